// File: rtl/hex_scroller_pkg.sv
// rtl/hex_scroller_pkg.sv - shared constants, state enum and glyph lookup for hex_scroller
//
// Purpose: character codes, mode encodings, FSM state type and the
//          character-to-segment function used by the display decoders.
// Ports:   none (package).

package hex_scroller_pkg;

    // Character codes accepted on char_in; codes 4..7 all render blank.
    localparam logic [2:0] CHAR_H     = 3'd0;
    localparam logic [2:0] CHAR_E     = 3'd1;
    localparam logic [2:0] CHAR_L     = 3'd2;
    localparam logic [2:0] CHAR_O     = 3'd3;
    localparam logic [2:0] CHAR_BLANK = 3'd4;

    // Display modes on the mode input.
    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
    localparam logic [1:0] MODE_RIGHT  = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [6:0] char_to_seg(input logic [2:0] code);
        logic [6:0] seg;
        case (code)
            CHAR_H:  seg = SEG_H;
            CHAR_E:  seg = SEG_E;
            CHAR_L:  seg = SEG_L;
            CHAR_O:  seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_scroller_seg7_char_decode.sv
// rtl/hex_scroller_seg7_char_decode.sv - combinational character code to seven-segment decode
//
// Purpose: maps one 3-bit character code to its active-low segment pattern.
// Ports:
//   i_char  in  3  character code
//   o_seg   out 7  active-low segments, bit 0 = a, bit 6 = g

module seg7_char_decode
    import hex_scroller_pkg::*;
(
    input  logic [2:0] i_char,
    output logic [6:0] o_seg
);

    assign o_seg = char_to_seg(i_char);

endmodule

// File: rtl/hex_scroller.sv
// rtl/hex_scroller.sv - seven-segment message engine with static/scroll/blink modes
//
// Purpose: holds a MSG_LEN-character message loaded over a valid/ready port and
//          drives NUM_DIGITS active-low HEX displays, stepping the view every
//          TICK_DIV cycles of RUN.
// Ports:
//   CLOCK_50    in   1                  clock, rising edge
//   reset       in   1                  synchronous active-high reset
//   mode        in   2                  0 static, 1 left, 2 right, 3 blink
//   pause       in   1                  freezes timer, offset and blink phase
//   load_start  in   1                  pulse: restart message loading
//   char_in     in   3                  character code
//   char_valid  in   1                  char_in is valid
//   char_ready  out  1                  high while loading
//   offset      out  clog2(MSG_LEN)     current scroll offset
//   HEX         out  NUM_DIGITS*7       active-low segments, digit 0 rightmost

module hex_scroller
    import hex_scroller_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 25_000_000
)
(
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic                         pause,
    input  logic                         load_start,
    input  logic [2:0]                   char_in,
    input  logic                         char_valid,
    output logic                         char_ready,
    output logic [$clog2(MSG_LEN)-1:0]   offset,
    output logic [NUM_DIGITS*7-1:0]      HEX
);

    localparam int OFF_W = $clog2(MSG_LEN);
    localparam int TMR_W = $clog2(TICK_DIV);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MSG_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TICK_DIV - 1);

    state_t                    r_state;
    logic [OFF_W-1:0]          r_wptr;
    logic [OFF_W-1:0]          r_offset;
    logic [TMR_W-1:0]          r_timer;
    logic                      r_blink;
    logic [2:0]                r_buf [MSG_LEN];
    logic [NUM_DIGITS*7-1:0]   r_hex;

    logic [NUM_DIGITS*7-1:0]   w_hex_next;
    logic                      w_accept;
    logic                      w_step;
    logic                      w_blank;

    assign char_ready = (r_state == ST_LOAD);
    assign offset     = r_offset;
    assign HEX        = r_hex;

    // A beat that coincides with load_start is dropped: the restart wins.
    assign w_accept = char_valid & char_ready & ~load_start;
    assign w_step   = (r_timer == TMR_LAST);
    // Gating with the live mode makes leaving BLINK unblank immediately,
    // even though r_blink itself clears on the following edge.
    assign w_blank  = r_blink & (mode == MODE_BLINK);

    // Digit d shows the character (offset + NUM_DIGITS-1-d) mod MSG_LEN, so
    // character 0 lands on the leftmost digit at offset 0 and short messages
    // repeat across the display.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic [OFF_W-1:0] w_idx;
        logic [6:0]       w_seg;

        assign w_idx = OFF_W'((32'(r_offset) + 32'(NUM_DIGITS - 1 - d)) % 32'(MSG_LEN));

        seg7_char_decode u_dec (
            .i_char (r_buf[w_idx]),
            .o_seg  (w_seg)
        );

        assign w_hex_next[d*7 +: 7] = w_seg;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= ST_LOAD;
            r_wptr   <= '0;
            r_offset <= '0;
            r_timer  <= '0;
            r_blink  <= 1'b0;
            r_hex    <= '1;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= CHAR_BLANK;
            end
        end else begin
            r_hex <= ((r_state == ST_LOAD) || w_blank) ? '1 : w_hex_next;

            case (r_state)
                ST_LOAD: begin
                    if (load_start) begin
                        r_wptr <= '0;
                    end else if (w_accept) begin
                        r_buf[r_wptr] <= char_in;
                        if (r_wptr == OFF_LAST) begin
                            r_state  <= ST_RUN;
                            r_wptr   <= '0;
                            r_offset <= '0;
                            r_timer  <= '0;
                            r_blink  <= 1'b0;
                        end else begin
                            r_wptr <= r_wptr + 1'b1;
                        end
                    end
                end

                ST_RUN, ST_HOLD: begin
                    if (load_start) begin
                        r_state  <= ST_LOAD;
                        r_wptr   <= '0;
                        r_offset <= '0;
                        r_timer  <= '0;
                        r_blink  <= 1'b0;
                    end else begin
                        if (pause) begin
                            r_state <= ST_HOLD;
                        end else if (r_state == ST_HOLD) begin
                            // The release cycle is still a HOLD cycle; the
                            // timer resumes counting once back in RUN.
                            r_state <= ST_RUN;
                        end else begin
                            r_timer <= w_step ? '0 : r_timer + 1'b1;
                            if (w_step) begin
                                case (mode)
                                    MODE_STATIC: ;
                                    MODE_LEFT:   r_offset <= (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
                                    MODE_RIGHT:  r_offset <= (r_offset == '0) ? OFF_LAST : r_offset - 1'b1;
                                    default:     r_blink  <= ~r_blink;
                                endcase
                            end
                        end
                        if (mode != MODE_BLINK) begin
                            r_blink <= 1'b0;
                        end
                    end
                end

                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scroller.sv
// tb/tb_hex_scroller.sv - directed scoreboard bench for hex_scroller

module tb_hex_scroller;

    localparam int ND = 8;
    localparam int ML = 8;
    localparam int TD = 4;

    localparam logic [63:0] ALL_ONES = 64'h00FF_FFFF_FFFF_FFFF;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        pause;
    logic        load_start;
    logic [2:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [2:0]  offset;
    logic [55:0] HEX;

    always #5 CLOCK_50 = ~CLOCK_50;

    hex_scroller #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .mode       (mode),
        .pause      (pause),
        .load_start (load_start),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .offset     (offset),
        .HEX        (HEX)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         n_total = 0;
    int         n_pass  = 0;
    logic [2:0] tb_msg [8];

    function automatic logic [6:0] pat(input logic [2:0] c);
        case (c)
            3'd0:    return 7'b0001001;
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1000111;
            3'd3:    return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [63:0] exp_hex(input int off, input bit blank);
        logic [63:0] r;
        logic [2:0]  ix;
        r = '0;
        for (int d = 0; d < ND; d++) begin
            ix = 3'((off + ND - 1 - d) % ML);
            r[d*7 +: 7] = blank ? 7'b1111111 : pat(tb_msg[ix]);
        end
        return r;
    endfunction

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_out(input logic [63:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: got %h expected a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        mode       = 2'd0;
        pause      = 1'b0;
        load_start = 1'b0;
        char_in    = 3'd0;
        char_valid = 1'b0;
        tb_msg     = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};

        // Reset state
        expect_val("hex_reset", ALL_ONES);
        expect_val("ready_reset", 64'd1);
        expect_val("offset_reset", 64'd0);
        tick();
        tick();
        check_out(64'(HEX));
        check_out(64'(char_ready));
        check_out(64'(offset));
        reset = 1'b0;

        // Load HELLO + three blanks
        for (int i = 0; i < 8; i++) begin
            char_in    = tb_msg[i];
            char_valid = 1'b1;
            expect_val("ready_loading", 64'd1);
            check_out(64'(char_ready));
            tick();
        end
        char_valid = 1'b0;
        expect_val("ready_after_last", 64'd0);
        expect_val("hex_blank_at_run_entry", ALL_ONES);
        check_out(64'(char_ready));
        check_out(64'(HEX));

        expect_val("hex_first_run", exp_hex(0, 0));
        tick();
        check_out(64'(HEX));

        // STATIC: nothing moves over many steps
        for (int i = 0; i < 39; i++) begin
            expect_val("hex_static", exp_hex(0, 0));
            tick();
            check_out(64'(HEX));
        end
        expect_val("offset_static", 64'd0);
        check_out(64'(offset));

        // LEFT: timer is at 0 here, so the step lands on the 4th edge
        mode = 2'd1;
        repeat (3) tick();
        expect_val("offset_left_pre", 64'd0);
        check_out(64'(offset));
        expect_val("offset_left_1", 64'd1);
        tick();
        check_out(64'(offset));
        expect_val("hex_left_1", exp_hex(1, 0));
        tick();
        check_out(64'(HEX));
        repeat (27) tick();
        expect_val("offset_left_wrap", 64'd0);
        check_out(64'(offset));
        expect_val("hex_left_wrap", exp_hex(0, 0));
        tick();
        check_out(64'(HEX));

        // RIGHT from offset 0: timer is 1, step after three edges
        mode = 2'd2;
        repeat (2) tick();
        expect_val("offset_right_pre", 64'd0);
        check_out(64'(offset));
        expect_val("offset_right_7", 64'd7);
        tick();
        check_out(64'(offset));
        expect_val("hex_right_7", exp_hex(7, 0));
        tick();
        check_out(64'(HEX));

        // Pause with timer = 2
        tick();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_val("offset_paused", 64'd7);
            tick();
            check_out(64'(offset));
        end
        pause = 1'b0;
        expect_val("offset_release_hold", 64'd7);
        tick();
        check_out(64'(offset));
        expect_val("offset_run_cycle_1", 64'd7);
        tick();
        check_out(64'(offset));
        expect_val("offset_run_cycle_2_step", 64'd6);
        tick();
        check_out(64'(offset));

        // BLINK: timer is 0, first toggle three edges after the next one
        mode = 2'd3;
        expect_val("hex_blink_start", exp_hex(6, 0));
        tick();
        check_out(64'(HEX));
        for (int k = 1; k <= 10; k++) begin
            expect_val("hex_blink", (k >= 4 && k <= 7) ? ALL_ONES : exp_hex(6, 0));
            tick();
            check_out(64'(HEX));
        end

        // load_start together with pause on a step cycle
        load_start = 1'b1;
        pause      = 1'b1;
        expect_val("ready_after_restart", 64'd1);
        expect_val("offset_after_restart", 64'd0);
        tick();
        check_out(64'(char_ready));
        check_out(64'(offset));
        load_start = 1'b0;
        pause      = 1'b0;
        expect_val("hex_blank_in_load", ALL_ONES);
        tick();
        check_out(64'(HEX));

        // A beat coinciding with load_start is dropped: eight more are needed
        char_in    = 3'd3;
        char_valid = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (7) tick();
        expect_val("ready_after_7_accepts", 64'd1);
        check_out(64'(char_ready));
        tick();
        char_valid = 1'b0;
        expect_val("ready_after_8_accepts", 64'd0);
        check_out(64'(char_ready));
        for (int i = 0; i < 8; i++) tb_msg[i] = 3'd3;
        expect_val("hex_all_o", exp_hex(0, 0));
        tick();
        check_out(64'(HEX));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hex_scroller.md
# hex_scroller

Parametrised seven-segment message engine for the DE2 HEX bank. Holds a MSG_LEN-character message loaded through a valid/ready port and drives NUM_DIGITS active-low displays. Supports four modes: static, scroll-left, scroll-right and blink, all paced by an internal step timer. Sits between switch/key input logic and the HEX pins, replacing hand-written per-display decode equations.

## Interface
- NUM_DIGITS, 8: number of HEX displays driven.
- MSG_LEN, 8: message buffer depth in characters; must be at least 2.
- TICK_DIV, 25_000_000: clock cycles per scroll/blink step; must be at least 2.
- CLOCK_50  in  1: sole clock, rising edge.
- reset  in  1: synchronous, active-high; overrides all other inputs.
- mode  in  2: 0 STATIC, 1 LEFT, 2 RIGHT, 3 BLINK.
- pause  in  1: freezes the step timer while high.
- load_start  in  1: pulse; abandons display and re-enters loading.
- char_in  in  3: character code.
- char_valid  in  1: char_in is valid.
- char_ready  out  1: high only in LOAD.
- offset  out  clog2(MSG_LEN): current scroll offset.
- HEX  out  NUM_DIGITS*7: active-low segments. Digit d occupies HEX[d*7+6:d*7], with bit 0 = segment a and bit 6 = segment g. HEX0 is d=0, the rightmost digit.

## Operation
- Character codes: 0 H, 1 E, 2 L, 3 O, 4–7 BLANK.
- Active-low patterns in g..a order:
  - H 7'b0001001
  - E 7'b0000110
  - L 7'b1000111
  - O 7'b1000000
  - BLANK 7'b1111111
- FSM states are LOAD, RUN and HOLD.
- Reset state:
  - State is LOAD.
  - Write pointer, offset, timer and blink phase are 0.
  - All buffer entries are BLANK.
  - HEX is all ones and char_ready is 1.
- LOAD:
  - A character is accepted on char_valid & char_ready. It is written to buf[wptr] and wptr increments.
  - The accept at wptr = MSG_LEN-1 moves the FSM to RUN. wptr clears and offset and timer are 0.
  - HEX is all BLANK throughout LOAD.
- RUN:
  - The timer counts 0..TICK_DIV-1 and wraps.
  - The wrap cycle is a step. On a step:
    - LEFT: offset = (offset+1) mod MSG_LEN.
    - RIGHT: offset = offset==0 ? MSG_LEN-1 : offset-1.
    - STATIC: offset is unchanged.
    - BLINK: blink phase toggles.
- HOLD:
  - Entered from RUN when pause = 1; returns to RUN when pause = 0.
  - Timer, offset and blink phase are frozen, and the timer resumes from its held value.
- Display mapping:
  - Digit d shows buf[(offset + NUM_DIGITS-1-d) mod MSG_LEN], so character 0 is leftmost at offset 0.
  - If MSG_LEN < NUM_DIGITS the message repeats across the display.
- BLINK display:
  - With blink phase 1, all digits are BLANK.
  - Leaving BLINK mode clears blink phase in the same cycle.
- Mode changes:
  - A new mode takes effect at the next step.
  - Offset is retained across mode changes.
- Priority, highest first: reset, then load_start, then pause, then step.
  - load_start in RUN or HOLD moves to LOAD and clears wptr, offset, timer and blink phase.
  - Buffer contents are kept until overwritten.
  - load_start in LOAD restarts wptr at 0.
- A char_valid beat that coincides with load_start is not accepted.

## Timing
- HEX is registered: 1 cycle after the state/offset/buffer change that produced it.
- char_ready is combinational from state. It drops the cycle after the last accept.
- First RUN display appears 1 cycle after entering RUN.
- Step period is exactly TICK_DIV cycles of RUN; cycles spent in HOLD are not counted.
- Offset wrap is exact, with no skipped or duplicated positions.

## Structure
- Package hex_scroller_pkg holds:
  - char code constants and mode encodings;
  - the FSM state enum;
  - a function mapping char code to the 7-bit active-low pattern.
- Sub-module seg7_char_decode is the pure combinational decode. Instantiate it NUM_DIGITS times via generate.
- Timer, FSM, buffer and offset logic live in hex_scroller.

## Test plan
All scenarios use NUM_DIGITS=8, MSG_LEN=8, TICK_DIV=4.
1. Reset held 2 cycles -> HEX = all ones (56 bits), char_ready=1, offset=0.
2. Load 0,1,2,2,3,4,4,4 with mode=STATIC -> char_ready=0 the cycle after the 8th accept. One cycle later, HEX7..HEX3 = H,E,L,L,O and HEX2..HEX0 = BLANK. No change over 40 cycles.
3. Mode=LEFT -> after 4 cycles offset=1, HEX7=E, HEX0=H. After 32 cycles offset=0 again, with the same display as step 2.
4. Mode=RIGHT from offset 0 -> one step gives offset=7, HEX7=BLANK, HEX6=H, HEX5=E.
5. pause high for 10 cycles with timer=2 -> offset unchanged during the pause. The step occurs exactly 2 RUN cycles after release.
6. Mode=BLINK -> HEX alternates all-BLANK and the message every 4 cycles. Then load_start in the same cycle as pause and a step -> LOAD next cycle, char_ready=1, offset=0, HEX all ones one cycle later.
